// File: rtl/laser_scan_ctrl.sv
// Two-circle centre search controller: scans all 16x16 candidate centres for one
// moving circle per pass, commits the best one, and alternates circles until converged.
module laser_scan_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [2:0] i_iter,
  output logic       o_cand_valid,
  input  logic       i_cand_ready,
  output logic [3:0] o_cand_x,
  output logic [3:0] o_cand_y,
  output logic       o_cand_sel,
  input  logic       i_hit_valid,
  input  logic [5:0] i_hit,
  output logic [3:0] o_c1x,
  output logic [3:0] o_c1y,
  output logic [3:0] o_c2x,
  output logic [3:0] o_c2y,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [2:0] r_iter;
  logic [3:0] r_cand_x;
  logic [3:0] r_cand_y;
  logic       r_sel;
  logic [5:0] r_hit;
  logic [5:0] r_best_cnt;
  logic [3:0] r_best_x;
  logic [3:0] r_best_y;
  logic [3:0] r_c1x;
  logic [3:0] r_c1y;
  logic [3:0] r_c2x;
  logic [3:0] r_c2y;
  logic [3:0] r_pass_cnt;
  logic       r_prev_unch;

  logic       w_win;
  logic [3:0] w_fin_x;
  logic [3:0] w_fin_y;
  logic       w_last;
  logic       w_unch;
  logic [3:0] w_pass_next;
  logic       w_terminate;

  // Winner including the candidate being evaluated this cycle; ties go to the later one.
  assign w_win       = (r_hit >= r_best_cnt);
  assign w_fin_x     = w_win ? r_cand_x : r_best_x;
  assign w_fin_y     = w_win ? r_cand_y : r_best_y;
  assign w_last      = (r_cand_x == 4'd15) && (r_cand_y == 4'd15);
  assign w_unch      = r_sel ? ((w_fin_x == r_c2x) && (w_fin_y == r_c2y))
                             : ((w_fin_x == r_c1x) && (w_fin_y == r_c1y));
  assign w_pass_next = r_pass_cnt + 4'd1;
  assign w_terminate = (w_pass_next == {r_iter, 1'b0}) || (w_unch && r_prev_unch);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_next = S_ISSUE;
      S_ISSUE:  if (i_cand_ready) w_state_next = S_WAIT;
      S_WAIT:   if (i_hit_valid) w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = (w_last && w_terminate) ? S_FINISH : S_ISSUE;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cand_valid = (r_state == S_ISSUE);
    o_done       = (r_state == S_FINISH);
    o_busy       = (r_state != S_IDLE);
  end

  assign o_cand_x   = r_cand_x;
  assign o_cand_y   = r_cand_y;
  assign o_cand_sel = r_sel;
  assign o_c1x      = r_c1x;
  assign o_c1y      = r_c1y;
  assign o_c2x      = r_c2x;
  assign o_c2y      = r_c2y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_iter      <= 3'd0;
      r_cand_x    <= 4'd0;
      r_cand_y    <= 4'd0;
      r_sel       <= 1'b0;
      r_hit       <= 6'd0;
      r_best_cnt  <= 6'd0;
      r_best_x    <= 4'd0;
      r_best_y    <= 4'd0;
      r_c1x       <= 4'd0;
      r_c1y       <= 4'd0;
      r_c2x       <= 4'd0;
      r_c2y       <= 4'd0;
      r_pass_cnt  <= 4'd0;
      r_prev_unch <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_iter      <= (i_iter == 3'd0) ? 3'd1 : i_iter;
            r_cand_x    <= 4'd0;
            r_cand_y    <= 4'd0;
            r_sel       <= 1'b0;
            r_best_cnt  <= 6'd0;
            r_best_x    <= 4'd0;
            r_best_y    <= 4'd0;
            r_c1x       <= 4'd0;
            r_c1y       <= 4'd0;
            r_c2x       <= 4'd0;
            r_c2y       <= 4'd0;
            r_pass_cnt  <= 4'd0;
            r_prev_unch <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_hit_valid) r_hit <= i_hit;
        end
        S_UPDATE: begin
          r_cand_x <= r_cand_x + 4'd1;
          if (r_cand_x == 4'd15) r_cand_y <= r_cand_y + 4'd1;
          if (w_last) begin
            if (r_sel) begin
              r_c2x <= w_fin_x;
              r_c2y <= w_fin_y;
            end else begin
              r_c1x <= w_fin_x;
              r_c1y <= w_fin_y;
            end
            r_pass_cnt  <= w_pass_next;
            r_sel       <= ~r_sel;
            r_best_cnt  <= 6'd0;
            r_best_x    <= 4'd0;
            r_best_y    <= 4'd0;
            r_prev_unch <= w_unch;
          end else if (w_win) begin
            r_best_cnt <= r_hit;
            r_best_x   <= r_cand_x;
            r_best_y   <= r_cand_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Scoreboard bench for laser_scan_ctrl: a behavioural search model queues the expected
// candidate stream and final centres; the engine stub answers each accepted candidate.
module tb_laser_scan_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [2:0] i_iter;
  logic       o_cand_valid;
  logic       i_cand_ready;
  logic [3:0] o_cand_x;
  logic [3:0] o_cand_y;
  logic       o_cand_sel;
  logic       i_hit_valid;
  logic [5:0] i_hit;
  logic [3:0] o_c1x;
  logic [3:0] o_c1y;
  logic [3:0] o_c2x;
  logic [3:0] o_c2y;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [3:0] exp_c1x, exp_c1y, exp_c2x, exp_c2y;

  always #5 i_clk = ~i_clk;

  laser_scan_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_iter       (i_iter),
    .o_cand_valid (o_cand_valid),
    .i_cand_ready (i_cand_ready),
    .o_cand_x     (o_cand_x),
    .o_cand_y     (o_cand_y),
    .o_cand_sel   (o_cand_sel),
    .i_hit_valid  (i_hit_valid),
    .i_hit        (i_hit),
    .o_c1x        (o_c1x),
    .o_c1y        (o_c1y),
    .o_c2x        (o_c2x),
    .o_c2y        (o_c2y),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Engine stub: hit count for a candidate centre under each scenario.
  function automatic logic [5:0] hit_fn(input int mode, input logic sel,
                                        input logic [3:0] x, input logic [3:0] y);
    logic [5:0] h;
    h = 6'd1;
    case (mode)
      0: begin
        h = 6'd1;
        if (!sel && x == 4'd3 && y == 4'd4) h = 6'd10;
        if (sel && x == 4'd12 && y == 4'd9) h = 6'd10;
      end
      1: h = 6'd5;
      default: begin
        h = 6'd3;
        if ((x == 4'd9 && y == 4'd1) || (x == 4'd2 && y == 4'd3)) h = 6'd20;
        if (sel && x == 4'd15 && y == 4'd15) h = 6'd20;
      end
    endcase
    return h;
  endfunction

  function automatic void build_model(input int mode, input logic [2:0] iter);
    int         it;
    int         passes;
    bit         prev_unch;
    bit         unch;
    bit         stop;
    logic       sel;
    logic [3:0] bx, by;
    logic [5:0] best, h;
    it = (iter == 3'd0) ? 1 : int'(iter);
    passes = 0;
    prev_unch = 1'b0;
    unch = 1'b0;
    stop = 1'b0;
    exp_c1x = 4'd0; exp_c1y = 4'd0; exp_c2x = 4'd0; exp_c2y = 4'd0;
    exp_q.delete();
    while (!stop) begin
      sel = passes[0];
      best = 6'd0; bx = 4'd0; by = 4'd0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          exp_q.push_back({sel, 4'(x), 4'(y)});
          h = hit_fn(mode, sel, 4'(x), 4'(y));
          if (h >= best) begin
            best = h; bx = 4'(x); by = 4'(y);
          end
        end
      end
      if (!sel) begin
        unch = (bx == exp_c1x) && (by == exp_c1y);
        exp_c1x = bx; exp_c1y = by;
      end else begin
        unch = (bx == exp_c2x) && (by == exp_c2y);
        exp_c2x = bx; exp_c2y = by;
      end
      passes++;
      stop = (passes == 2 * it) || (unch && prev_unch);
      prev_unch = unch;
    end
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({o_cand_valid, o_cand_x, o_cand_y, o_cand_sel,
                o_c1x, o_c1y, o_c2x, o_c2y, o_busy, o_done});
  endfunction

  task automatic idle_quiet(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk(tag, 32'({o_busy, o_cand_valid, o_done}), 32'd0);
    end
  endtask

  // One run: mode selects the engine answers; stall holds READY low 3 cycles on (7,2);
  // noisy feeds a bogus HIT in ISSUE and pulses START mid-run; rst_at > 0 resets after that many handshakes.
  task automatic run_scan(input string name, input int mode, input logic [2:0] iter,
                          input bit stall, input bit noisy, input int rst_at);
    int         cyc, hs, n_cand, stall_cnt, exp_done;
    bit         held_v, finished;
    logic [8:0] held, c;
    build_model(mode, iter);
    n_cand    = exp_q.size();
    exp_done  = 3 * n_cand + 1 + (stall ? 3 : 0);
    stall_cnt = 0; held_v = 1'b0; held = 9'd0; hs = 0; finished = 1'b0;
    i_iter = iter;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    if (noisy) i_iter = 3'd7;
    cyc = 1;
    chk({name, "_busy_start"}, 32'(o_busy), 32'd1);
    while (!finished && cyc < 5000) begin
      c = {o_cand_sel, o_cand_x, o_cand_y};
      if (held_v) chk({name, "_stall_hold"}, 32'({o_cand_valid, c}), 32'({1'b1, held}));
      held_v = 1'b0;
      if (rst_at > 0 && hs == rst_at) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk({name, "_rst_outputs"}, all_outs(), 32'd0);
        $display("%s: reset after %0d candidates", name, hs);
        exp_q.delete();
        finished = 1'b1;
      end else if (o_done) begin
        chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        chk({name, "_busy_done"}, 32'(o_busy), 32'd1);
        chk({name, "_c1"}, 32'({o_c1x, o_c1y}), 32'({exp_c1x, exp_c1y}));
        chk({name, "_c2"}, 32'({o_c2x, o_c2y}), 32'({exp_c2x, exp_c2y}));
        chk({name, "_cands_left"}, 32'(exp_q.size()), 32'd0);
        $display("%s: done cycle %0d, %0d candidates, C1=(%0d,%0d) C2=(%0d,%0d)",
                 name, cyc, hs, o_c1x, o_c1y, o_c2x, o_c2y);
        @(negedge i_clk);
        chk({name, "_done_pulse"}, 32'({o_done, o_busy}), 32'd0);
        finished = 1'b1;
      end else begin
        i_hit_valid = 1'b1;
        i_hit = (noisy && o_cand_valid) ? 6'd40 : hit_fn(mode, o_cand_sel, o_cand_x, o_cand_y);
        i_start = noisy && o_cand_valid && (c == 9'h055);
        i_cand_ready = 1'b1;
        if (stall && o_cand_valid && c == 9'h072 && stall_cnt < 3) begin
          i_cand_ready = 1'b0;
          stall_cnt++;
          held_v = 1'b1;
          held = c;
        end
        if (o_cand_valid && i_cand_ready) begin
          if (exp_q.size() == 0) chk({name, "_extra_cand"}, 32'd0, 32'd1);
          else chk({name, "_cand"}, 32'(c), 32'(exp_q.pop_front()));
          hs++;
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    i_start = 1'b0;
    if (!finished) chk({name, "_timeout"}, 32'(cyc), 32'(exp_done));
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_iter = 3'd0;
    i_cand_ready = 1'b1;
    i_hit_valid = 1'b0;
    i_hit = 6'd0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", all_outs(), 32'd0);
    i_rst = 1'b0;
    i_hit_valid = 1'b1;
    i_hit = 6'd40;
    idle_quiet("idle_after_reset");

    run_scan("basic_iter1", 0, 3'd1, 1'b0, 1'b0, 0);
    run_scan("const5_iter4", 1, 3'd4, 1'b0, 1'b0, 0);
    run_scan("ready_stall", 0, 3'd1, 1'b1, 1'b0, 0);
    run_scan("tie_noisy", 2, 3'd1, 1'b0, 1'b1, 0);
    run_scan("mid_reset", 0, 3'd2, 1'b0, 1'b0, 356);
    i_hit = 6'd40;
    idle_quiet("idle_after_midrst");
    run_scan("iter0", 0, 3'd0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
